// File: rtl/dffram_burst.sv
// dffram_burst: byte-addressable DFF RAM with an auto-incrementing pointer, registered reads and a multi-cycle FILL.
module dffram_burst #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH_WORDS = 32,
  localparam int NBYTES = WORD_BYTES * DEPTH_WORDS,
  localparam int AW = $clog2(NBYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_arg,
  input  logic [7:0]    cmd_data,
  input  logic          auto_inc,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] ptr,
  output logic          wrapped,
  output logic          busy
);
  localparam int LB = $clog2(WORD_BYTES);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_FILL = 1'b1;
  localparam logic [1:0] OP_SET = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_RD = 2'd2;
  localparam logic [1:0] OP_FILL = 2'd3;

  logic                      state;
  logic [7:0]                fill_val;
  logic [AW-1:0]             fill_cnt;
  logic [8*WORD_BYTES-1:0]   mem [DEPTH_WORDS];
  logic                      acc, filling, we, inc;
  logic [7:0]                wdata;
  logic [AW-LB-1:0]          word;
  logic [AW+2:0]             bit_ofs;

  assign cmd_ready = ena & (state == S_IDLE);
  assign busy = state == S_FILL;
  assign acc = cmd_valid & cmd_ready;
  assign filling = ena & busy;
  assign we = rst_n & (filling | (acc & (cmd_op == OP_WR)));
  assign inc = filling | (acc & auto_inc & ((cmd_op == OP_WR) | (cmd_op == OP_RD)));
  assign wdata = filling ? fill_val : cmd_data;
  assign word = ptr[AW-1:LB];
  assign bit_ofs = {ptr & AW'(WORD_BYTES - 1), 3'b000};

  // Storage is deliberately unreset; only the addressed byte lane is written.
  always_ff @(posedge clk)
    if (we) mem[word][bit_ofs +: 8] <= wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      wrapped <= 1'b0;
      state <= S_IDLE;
      fill_val <= '0;
      fill_cnt <= '0;
    end else begin
      rd_valid <= acc & (cmd_op == OP_RD);
      if (acc & (cmd_op == OP_RD)) rd_data <= 8'(mem[word] >> bit_ofs);
      if (acc & (cmd_op == OP_SET)) begin
        ptr <= cmd_arg;
        wrapped <= 1'b0;
      end else if (inc) begin
        ptr <= ptr + AW'(1);
        if (ptr == '1) wrapped <= 1'b1;
      end
      if (acc & (cmd_op == OP_FILL)) begin
        state <= S_FILL;
        fill_val <= cmd_data;
        fill_cnt <= cmd_arg;
      end else if (filling) begin
        if (fill_cnt == '0) state <= S_IDLE;
        else fill_cnt <= fill_cnt - AW'(1);
      end
    end
  end
endmodule
